// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and helpers for the PIC control unit.
// Contents:
//   init_state_e / ack_state_e - init and acknowledge FSM encodings.
//   EOI_NS / EOI_SP            - OCW2 command codes (bits [7:5]).
//   CALL_OPCODE                - first byte returned in 8080 acknowledge mode.
//   onehot_to_index            - encodes a (one-hot) 32-bit vector to an index.
//   lowest_set_onehot          - isolates the lowest set bit of a 32-bit vector.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE_UNINIT,
    ICW2,
    ICW3,
    ICW4,
    READY
  } init_state_e;

  typedef enum logic [2:0] {
    CTRL_READY,
    ACK1,
    ACK2,
    ACK3,
    POLL
  } ack_state_e;

  localparam logic [2:0] EOI_NS      = 3'b001;
  localparam logic [2:0] EOI_SP      = 3'b011;
  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // The input is expected one-hot; if several bits are set the highest wins.
  function automatic logic [4:0] onehot_to_index(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [31:0] lowest_set_onehot(input logic [31:0] vec);
    return vec & (~vec + 32'd1);
  endfunction

endpackage

// File: rtl/pic_edge_detect.sv
// pic_edge_detect: registered edge detector for an active-low bus strobe.
// Ports:
//   clk_i   - system clock
//   reset_i - synchronous active-high reset (history register resets high)
//   sig_i   - strobe being watched
//   rise_o  - high in the cycle sig_i is first seen high after being low
//   fall_o  - high in the cycle sig_i is first seen low after being high
module pic_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) sig_q <= 1'b1;
    else         sig_q <= sig_i;
  end

  assign fall_o = sig_q & ~sig_i;
  assign rise_o = ~sig_q & sig_i;

endmodule

// File: rtl/pic_control_unit_param.sv
// pic_control_unit_param: 8259A-style control unit for NUM_IRQ (8/16/32)
// channels. Sequences ICW1..ICW4, holds the mask (OCW1), issues EOI clears
// (OCW2), and runs the INTA acknowledge / poll FSM driving the data bus byte.
// Optional build macro PIC_AUTO_EOI_EN: enables automatic EOI (ICW4 AEOI bit).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   write_icw1..ocw3      - one-cycle register write strobes, data on data_bus
//   inta_n, rd_n          - acknowledge and read strobes, active low
//   interrupt, in_service - resolver request (one-hot) and current ISR
//   int_out               - interrupt request to the CPU
//   latch_isr             - pulse: ISR samples `interrupt`
//   end_of_ack/poll       - pulses at the end of an acknowledge / poll read
//   eoi_clear             - one-cycle ISR clear mask
//   imr, level_triggered  - mask register, ICW1 LTIM
//   data_out, data_out_en - vector / poll byte and its enable
//   init_done             - initialisation sequence complete
module pic_control_unit_param
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_icw1,
  input  logic               write_icw2_4,
  input  logic               write_ocw1,
  input  logic               write_ocw2,
  input  logic               write_ocw3,
  input  logic [7:0]         data_bus,
  input  logic               inta_n,
  input  logic               rd_n,
  input  logic [NUM_IRQ-1:0] interrupt,
  input  logic [NUM_IRQ-1:0] in_service,
  output logic               int_out,
  output logic               latch_isr,
  output logic               end_of_ack,
  output logic               end_of_poll,
  output logic [NUM_IRQ-1:0] eoi_clear,
  output logic [NUM_IRQ-1:0] imr,
  output logic               level_triggered,
  output logic [7:0]         data_out,
  output logic               data_out_en,
  output logic               init_done
);

  localparam int ID_W       = $clog2(NUM_IRQ);
  localparam int MASK_BYTES = NUM_IRQ / 8;
  localparam int PTR_W      = (MASK_BYTES > 1) ? $clog2(MASK_BYTES) : 1;
  localparam logic [NUM_IRQ-1:0] IRQ_ONE = NUM_IRQ'(1);

  init_state_e init_state_q, init_state_d;
  ack_state_e  ack_state_q,  ack_state_d;

  logic               ltim_q, ltim_d;
  logic               sngl_q, sngl_d;
  logic               ic4_q,  ic4_d;
  logic               upm_q,  upm_d;
`ifdef PIC_AUTO_EOI_EN
  logic               aeoi_q, aeoi_d;
`endif
  logic [7:ID_W]      vb_q, vb_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               pending_q, pending_d;
  logic               rd_seen_q, rd_seen_d;

  logic               int_out_q, int_out_d;
  logic               latch_isr_q, latch_isr_d;
  logic               end_of_ack_q, end_of_ack_d;
  logic               end_of_poll_q, end_of_poll_d;
  logic [NUM_IRQ-1:0] eoi_clear_q, eoi_clear_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_out_en_q, data_out_en_d;

  logic inta_rise, inta_fall, rd_rise, rd_fall;
  logic ocw_ok, poll_req, latch_now;
  logic [7:0] poll_byte;

  pic_edge_detect u_inta_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .sig_i   (inta_n),
    .rise_o  (inta_rise),
    .fall_o  (inta_fall)
  );

  pic_edge_detect u_rd_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .sig_i   (rd_n),
    .rise_o  (rd_rise),
    .fall_o  (rd_fall)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      init_state_q  <= IDLE_UNINIT;
      ack_state_q   <= CTRL_READY;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      upm_q         <= 1'b0;
`ifdef PIC_AUTO_EOI_EN
      aeoi_q        <= 1'b0;
`endif
      vb_q          <= '0;
      imr_q         <= '1;
      ptr_q         <= '0;
      id_q          <= '0;
      pending_q     <= 1'b0;
      rd_seen_q     <= 1'b0;
      int_out_q     <= 1'b0;
      latch_isr_q   <= 1'b0;
      end_of_ack_q  <= 1'b0;
      end_of_poll_q <= 1'b0;
      eoi_clear_q   <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
    end else begin
      init_state_q  <= init_state_d;
      ack_state_q   <= ack_state_d;
      ltim_q        <= ltim_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      upm_q         <= upm_d;
`ifdef PIC_AUTO_EOI_EN
      aeoi_q        <= aeoi_d;
`endif
      vb_q          <= vb_d;
      imr_q         <= imr_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      pending_q     <= pending_d;
      rd_seen_q     <= rd_seen_d;
      int_out_q     <= int_out_d;
      latch_isr_q   <= latch_isr_d;
      end_of_ack_q  <= end_of_ack_d;
      end_of_poll_q <= end_of_poll_d;
      eoi_clear_q   <= eoi_clear_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
    end
  end

  // Next-state logic for both FSMs and the configuration registers
  always_comb begin
    init_state_d = init_state_q;
    ack_state_d  = ack_state_q;
    ltim_d       = ltim_q;
    sngl_d       = sngl_q;
    ic4_d        = ic4_q;
    upm_d        = upm_q;
`ifdef PIC_AUTO_EOI_EN
    aeoi_d       = aeoi_q;
`endif
    vb_d         = vb_q;
    imr_d        = imr_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    pending_d    = pending_q;
    rd_seen_d    = rd_seen_q;
    latch_now    = 1'b0;

    // ICW1 takes priority over any OCW arriving in the same cycle.
    ocw_ok   = (init_state_q == READY) && !write_icw1;
    poll_req = ocw_ok && write_ocw3 && data_bus[2];

    if (write_icw1) begin
      // uPM/AEOI only come back if an ICW4 follows.
      ltim_d       = data_bus[3];
      sngl_d       = data_bus[1];
      ic4_d        = data_bus[0];
      upm_d        = 1'b0;
`ifdef PIC_AUTO_EOI_EN
      aeoi_d       = 1'b0;
`endif
      imr_d        = '1;
      ptr_d        = '0;
      rd_seen_d    = 1'b0;
      ack_state_d  = CTRL_READY;
      init_state_d = ICW2;
    end else begin
      if (write_icw2_4) begin
        unique case (init_state_q)
          ICW2: begin
            vb_d = data_bus[7:ID_W];
            if (!sngl_q)    init_state_d = ICW3;
            else if (ic4_q) init_state_d = ICW4;
            else            init_state_d = READY;
          end
          // Cascade configuration is not used by this block.
          ICW3: init_state_d = ic4_q ? ICW4 : READY;
          ICW4: begin
            upm_d = data_bus[0];
`ifdef PIC_AUTO_EOI_EN
            aeoi_d = data_bus[1];
`endif
            init_state_d = READY;
          end
          default: ;
        endcase
      end

      if (ocw_ok && write_ocw1) begin
        for (int b = 0; b < MASK_BYTES; b++) begin
          if (ptr_q == PTR_W'(b)) imr_d[b*8 +: 8] = data_bus;
        end
        ptr_d = (ptr_q == PTR_W'(MASK_BYTES - 1)) ? '0 : ptr_q + 1'b1;
      end
      if (ocw_ok && (write_ocw2 || write_ocw3)) ptr_d = '0;

      unique case (ack_state_q)
        CTRL_READY: begin
          if (poll_req) begin
            ack_state_d = POLL;
            rd_seen_d   = 1'b0;
            latch_now   = 1'b1;
          end else if (inta_fall && (init_state_q == READY)) begin
            ack_state_d = ACK1;
            latch_now   = 1'b1;
          end
        end
        ACK1: if (inta_rise) ack_state_d = ACK2;
        ACK2: if (inta_rise) ack_state_d = upm_q ? CTRL_READY : ACK3;
        ACK3: if (inta_rise) ack_state_d = CTRL_READY;
        POLL: begin
          // A poll completes only on a full read pulse seen inside POLL.
          if (rd_fall) begin
            rd_seen_d = 1'b1;
          end else if (rd_rise && rd_seen_q) begin
            rd_seen_d   = 1'b0;
            ack_state_d = CTRL_READY;
          end
        end
        default: ack_state_d = CTRL_READY;
      endcase

      if (latch_now) begin
        id_d      = ID_W'(onehot_to_index(32'(interrupt)));
        pending_d = |interrupt;
      end
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    poll_byte            = '0;
    poll_byte[7]         = pending_q;
    poll_byte[ID_W-1:0]  = id_q;

    latch_isr_d   = latch_now;
    end_of_ack_d  = ((ack_state_q == ACK2) || (ack_state_q == ACK3)) &&
                    (ack_state_d == CTRL_READY) && !write_icw1;
    end_of_poll_d = (ack_state_q == POLL) && (ack_state_d == CTRL_READY) &&
                    !write_icw1;
    // Uses next state so the request drops as the FSM leaves CTRL_READY.
    int_out_d     = (init_state_d == READY) && (ack_state_d == CTRL_READY) &&
                    (|interrupt);

    eoi_clear_d = '0;
    if (ocw_ok && write_ocw2) begin
      unique case (data_bus[7:5])
        EOI_NS:  eoi_clear_d = NUM_IRQ'(lowest_set_onehot(32'(in_service)));
        EOI_SP:  eoi_clear_d = IRQ_ONE << ID_W'(data_bus[4:0]);
        default: ;
      endcase
    end
`ifdef PIC_AUTO_EOI_EN
    if (end_of_ack_d && aeoi_q) eoi_clear_d = eoi_clear_d | (IRQ_ONE << id_q);
`endif

    data_out_d    = '0;
    data_out_en_d = 1'b0;
    unique case (ack_state_q)
      ACK1: begin
        data_out_d    = upm_q ? 8'h00 : CALL_OPCODE;
        data_out_en_d = ~inta_n;
      end
      ACK2: begin
        data_out_d    = {vb_q, id_q};
        data_out_en_d = ~inta_n;
      end
      ACK3: begin
        data_out_d    = {vb_q, ID_W'(0)};
        data_out_en_d = ~inta_n;
      end
      POLL: begin
        data_out_d    = poll_byte;
        data_out_en_d = ~rd_n;
      end
      default: ;
    endcase
    if (write_icw1) data_out_en_d = 1'b0;
  end

  assign int_out         = int_out_q;
  assign latch_isr       = latch_isr_q;
  assign end_of_ack      = end_of_ack_q;
  assign end_of_poll     = end_of_poll_q;
  assign eoi_clear       = eoi_clear_q;
  assign imr             = imr_q;
  assign level_triggered = ltim_q;
  assign data_out        = data_out_q;
  assign data_out_en     = data_out_en_q;
  assign init_done       = (init_state_q == READY);

endmodule

// File: tb/tb_pic_control_unit_param.sv
// Bench for pic_control_unit_param: an 8-channel and a 16-channel instance
// share clock, reset and the write strobes; expectations are queued when
// stimulus is driven and popped as the DUT outputs are sampled.
module tb_pic_control_unit_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w_icw1 = 0, w_icw24 = 0, w_ocw1 = 0, w_ocw2 = 0, w_ocw3 = 0;
  logic [7:0] data_bus = '0;
  logic inta_n = 1'b1, rd_n = 1'b1;
  logic [7:0] interrupt = '0, in_service = '0;

  logic int_out8, latch_isr8, end_of_ack8, end_of_poll8, ltim8, data_out_en8, init_done8;
  logic [7:0] eoi_clear8, imr8, data_out8;

  logic inta16_n = 1'b1, rd16_n = 1'b1;
  logic [15:0] interrupt16 = '0, in_service16 = '0;
  logic int_out16, latch_isr16, end_of_ack16, end_of_poll16, ltim16, data_out_en16, init_done16;
  logic [15:0] eoi_clear16, imr16;
  logic [7:0] data_out16;

  always #5 clk = ~clk;

  pic_control_unit_param #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .reset(reset),
    .write_icw1(w_icw1), .write_icw2_4(w_icw24), .write_ocw1(w_ocw1),
    .write_ocw2(w_ocw2), .write_ocw3(w_ocw3), .data_bus(data_bus),
    .inta_n(inta_n), .rd_n(rd_n), .interrupt(interrupt), .in_service(in_service),
    .int_out(int_out8), .latch_isr(latch_isr8), .end_of_ack(end_of_ack8),
    .end_of_poll(end_of_poll8), .eoi_clear(eoi_clear8), .imr(imr8),
    .level_triggered(ltim8), .data_out(data_out8), .data_out_en(data_out_en8),
    .init_done(init_done8)
  );

  pic_control_unit_param #(.NUM_IRQ(16)) dut16 (
    .clk(clk), .reset(reset),
    .write_icw1(w_icw1), .write_icw2_4(w_icw24), .write_ocw1(w_ocw1),
    .write_ocw2(w_ocw2), .write_ocw3(w_ocw3), .data_bus(data_bus),
    .inta_n(inta16_n), .rd_n(rd16_n), .interrupt(interrupt16), .in_service(in_service16),
    .int_out(int_out16), .latch_isr(latch_isr16), .end_of_ack(end_of_ack16),
    .end_of_poll(end_of_poll16), .eoi_clear(eoi_clear16), .imr(imr16),
    .level_triggered(ltim16), .data_out(data_out16), .data_out_en(data_out_en16),
    .init_done(init_done16)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow got=%h want=none", got);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0=ICW1 1=ICW2..4 2=OCW1 3=OCW2 4=OCW3
  task automatic wr(input int kind, input logic [7:0] d);
    data_bus = d;
    w_icw1  = (kind == 0);
    w_icw24 = (kind == 1);
    w_ocw1  = (kind == 2);
    w_ocw2  = (kind == 3);
    w_ocw3  = (kind == 4);
    tick();
    {w_icw1, w_icw24, w_ocw1, w_ocw2, w_ocw3} = '0;
  endtask

  task automatic inta_pulse(output logic [7:0] d, output logic en,
                            output logic li, output logic eoa);
    inta_n = 1'b0;
    tick();
    li = latch_isr8;
    tick();
    d  = data_out8;
    en = data_out_en8;
    inta_n = 1'b1;
    tick();
    eoa = end_of_ack8;
  endtask

  task automatic rd_read(output logic [7:0] d, output logic en, output logic eop);
    rd_n = 1'b0;
    tick();
    tick();
    d  = data_out8;
    en = data_out_en8;
    rd_n = 1'b1;
    eop = 1'b0;
    for (int i = 0; i < 8 && !eop; i++) begin
      tick();
      eop = end_of_poll8;
    end
  endtask

  logic [7:0] d;
  logic en, li, eoa, eop;

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    push("rst_imr8", 32'hFF);    pop_chk(imr8);
    push("rst_imr16", 32'hFFFF); pop_chk(imr16);
    push("rst_init", 0);         pop_chk(init_done8);
    push("rst_int", 0);          pop_chk(int_out8);
    push("rst_den", 0);          pop_chk(data_out_en8);
    reset = 1'b0;
    tick();

    // Init 8086 mode: ICW3 skipped (SNGL), ICW4 present
    wr(0, 8'h13);
    wr(1, 8'h40);
    push("init_mid", 0); pop_chk(init_done8);
    wr(1, 8'h01);
    push("init_done", 1);    pop_chk(init_done8);
    push("init_done16", 1);  pop_chk(init_done16);
    push("init_imr", 32'hFF); pop_chk(imr8);
    push("init_ltim", 0);    pop_chk(ltim8);

    // 8086 acknowledge, IRQ3
    interrupt = 8'h08;
    tick();
    push("x86_int", 1); pop_chk(int_out8);
    push("x86_li", 1); push("x86_en1", 1); push("x86_eoa1", 0);
    inta_pulse(d, en, li, eoa);
    pop_chk(li); pop_chk(en); pop_chk(eoa);
    interrupt = 8'h00;
    push("x86_vec", 32'h43); push("x86_en2", 1); push("x86_eoa2", 1);
    inta_pulse(d, en, li, eoa);
    pop_chk(d); pop_chk(en); pop_chk(eoa);
    tick();
    push("x86_eoa_pulse", 0); pop_chk(end_of_ack8);

    // 8080 mode: ICW4 omitted, three pulses
    wr(0, 8'h12);
    wr(1, 8'h40);
    push("i80_done", 1); pop_chk(init_done8);
    interrupt = 8'h08;
    tick();
    push("i80_cd", 32'hCD); push("i80_li", 1);
    inta_pulse(d, en, li, eoa);
    pop_chk(d); pop_chk(li);
    push("i80_vec", 32'h43); push("i80_eoa2", 0);
    inta_pulse(d, en, li, eoa);
    pop_chk(d); pop_chk(eoa);
    interrupt = 8'h00;
    push("i80_base", 32'h40); push("i80_eoa3", 1);
    inta_pulse(d, en, li, eoa);
    pop_chk(d); pop_chk(eoa);
    tick();

    // EOI commands
    in_service = 8'h24;
    wr(3, 8'h20);
    push("eoi_ns", 32'h04); pop_chk(eoi_clear8);
    tick();
    push("eoi_one_cycle", 0); pop_chk(eoi_clear8);
    wr(3, 8'h65);
    push("eoi_sp", 32'h20); pop_chk(eoi_clear8);
    wr(3, 8'h6B);
    push("eoi_sp_trunc8", 32'h08);    pop_chk(eoi_clear8);
    push("eoi_sp_idx16", 32'h0800);   pop_chk(eoi_clear16);
    in_service = 8'h00;
    wr(3, 8'h20);
    push("eoi_ns_empty", 0); pop_chk(eoi_clear8);
    wr(3, 8'hA0);
    push("eoi_other", 0); pop_chk(eoi_clear8);

    // Poll mode
    interrupt = 8'h02;
    wr(4, 8'h0C);
    push("poll_li", 1); pop_chk(latch_isr8);
    push("poll_byte", 32'h81); push("poll_en", 1); push("poll_eop", 1);
    rd_read(d, en, eop);
    pop_chk(d); pop_chk(en); pop_chk(eop);

    // OCW3 poll wins over a simultaneous INTA falling edge
    inta_n = 1'b0;
    wr(4, 8'h0C);
    tick();
    inta_n = 1'b1;
    tick();
    push("prio_byte", 32'h81); push("prio_en", 1); push("prio_eop", 1);
    rd_read(d, en, eop);
    pop_chk(d); pop_chk(en); pop_chk(eop);
    interrupt = 8'h00;
    tick();

    // Mask bytes: 16-channel pointer walks and wraps, 8-channel overwrites
    wr(2, 8'hF0);
    wr(2, 8'h0F);
    push("imr16_two", 32'h0FF0); pop_chk(imr16);
    push("imr8_two", 32'h0F);    pop_chk(imr8);
    wr(2, 8'hAA);
    push("imr16_wrap", 32'h0FAA); pop_chk(imr16);
    push("imr8_wrap", 32'hAA);    pop_chk(imr8);

    // ICW1 during ACK2 aborts the acknowledge
    interrupt = 8'h08;
    tick();
    inta_pulse(d, en, li, eoa);
    inta_n = 1'b0;
    tick();
    push("abort_in_ack2", 32'h43); pop_chk(data_out8);
    wr(0, 8'h13);
    push("abort_eoa", 0);   pop_chk(end_of_ack8);
    push("abort_eoi", 0);   pop_chk(eoi_clear8);
    push("abort_init", 0);  pop_chk(init_done8);
    push("abort_imr", 32'hFF); pop_chk(imr8);
    inta_n = 1'b1;
    tick();
    push("abort_eoa_late", 0); pop_chk(end_of_ack8);
    push("abort_int", 0);      pop_chk(int_out8);
    interrupt = 8'h00;

    // Re-init with LTIM set
    wr(0, 8'h1B);
    wr(1, 8'h40);
    wr(1, 8'h01);
    push("ltim_set", 1);  pop_chk(ltim8);
    push("ltim_done", 1); pop_chk(init_done8);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
